// File: rtl/dmem_responder.sv
// Data-memory slave for the MEM stage: a valid/ready request is followed by WAIT_CYCLES wait states
// and then a one-cycle response pulse that carries the load data and a fault flag.
module dmem_responder #(
  parameter int ADDR_W      = 10,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        req_ready,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic        we_q, we_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;
  logic [3:0]  be_q, be_d;

  logic [31:0] mem_q [2**ADDR_W];

  logic              enter_resp;
  logic              acc_we;
  logic [31:0]       acc_addr;
  logic [31:0]       acc_wdata;
  logic [3:0]        acc_be;
  logic [ADDR_W-1:0] acc_idx;
  logic              acc_err;
  logic              mem_wr;

  // With WAIT_CYCLES=0 the access executes on the accept edge itself, so the
  // live request fields are used in IDLE and the latched copy everywhere else.
  always_comb begin
    if (state_q == S_IDLE) begin
      acc_we    = req_we;
      acc_addr  = req_addr;
      acc_wdata = req_wdata;
      acc_be    = req_be;
    end else begin
      acc_we    = we_q;
      acc_addr  = addr_q;
      acc_wdata = wdata_q;
      acc_be    = be_q;
    end
    acc_idx = acc_addr[ADDR_W+1:2];
    acc_err = (acc_addr[1:0] != 2'b00) | (acc_addr[31:ADDR_W+2] != '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      busy_q  <= 1'b0;
      rdata_q <= 32'd0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    we_q    <= we_d;
    addr_q  <= addr_d;
    wdata_q <= wdata_d;
    be_q    <= be_d;
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy_d     = busy_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    enter_resp = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          be_d    = req_be;
          cnt_d   = 4'(WAIT_CYCLES);
          busy_d  = 1'b1;
          if (WAIT_CYCLES == 0) begin
            state_d    = S_RESP;
            enter_resp = 1'b1;
          end else begin
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (cnt_q <= 4'd1) begin
          cnt_d      = 4'd0;
          state_d    = S_RESP;
          enter_resp = 1'b1;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Response data is captured on the RESP-entry edge; stores leave rdata untouched.
  always_comb begin
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      err_d = acc_err;
      if (!acc_we) rdata_d = acc_err ? 32'd0 : mem_q[acc_idx];
    end
  end

  // Gating with rst_n keeps a zero-wait store from committing while reset is held.
  assign mem_wr = enter_resp & acc_we & ~acc_err & rst_n;

  always_ff @(posedge clk) begin
    if (mem_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
      end
    end
  end

  always_comb begin
    req_ready = (state_q == S_IDLE);
    rsp_valid = (state_q == S_RESP);
    rsp_rdata = rdata_q;
    rsp_err   = err_q;
    busy      = busy_q;
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: unit A uses two wait states, unit B uses zero wait states for back-to-back traffic.
module tb_dmem_responder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid_a = 1'b0;
  logic        req_valid_b = 1'b0;
  logic        req_we = 1'b0;
  logic [31:0] req_addr = 32'd0;
  logic [31:0] req_wdata = 32'd0;
  logic [3:0]  req_be = 4'd0;

  logic        req_ready_a, rsp_valid_a, rsp_err_a, busy_a;
  logic [31:0] rsp_rdata_a;
  logic        req_ready_b, rsp_valid_b, rsp_err_b, busy_b;
  logic [31:0] rsp_rdata_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_a), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready_a), .rsp_valid(rsp_valid_a), .rsp_rdata(rsp_rdata_a),
    .rsp_err(rsp_err_a), .busy(busy_a)
  );

  dmem_responder #(.ADDR_W(10), .WAIT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid_b), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .req_ready(req_ready_b), .rsp_valid(rsp_valid_b), .rsp_rdata(rsp_rdata_b),
    .rsp_err(rsp_err_b), .busy(busy_b)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // One access on unit A; returns the response fields and the cycle count from accept to rsp_valid.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] be, input bit scramble,
                     output logic [31:0] rd, output logic er, output int lat);
    @(negedge clk);
    chk("ready_idle", req_ready_a, 1'b1);
    req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    req_valid_a = 1'b1;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    lat = 0; rd = 32'd0; er = 1'b0;
    while (lat < 20) begin
      @(negedge clk);
      lat++;
      if (lat == 1) begin
        chk("busy_wait", busy_a, 1'b1);
        chk("ready_wait", req_ready_a, 1'b0);
      end
      if (scramble) begin
        req_addr = $urandom; req_we = ~req_we; req_wdata = $urandom;
      end
      if (rsp_valid_a) break;
    end
    rd = rsp_rdata_a; er = rsp_err_a;
    @(negedge clk);
    chk("rsp_one_cycle", rsp_valid_a, 1'b0);
    chk("busy_cleared", busy_a, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;

    // reset state
    #12;
    chk("rst_ready", req_ready_a, 1'b1);
    chk("rst_rsp_valid", rsp_valid_a, 1'b0);
    chk("rst_busy", busy_a, 1'b0);
    chk("rst_rdata", rsp_rdata_a, 32'd0);
    chk("rst_err", rsp_err_a, 1'b0);
    @(negedge clk); rst_n = 1'b1;

    // 1: preload mem[4] then load it, checking latency
    txn(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lat);
    chk("st10_lat", lat, 3);
    chk("st10_err", er, 1'b0);
    txn(1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld10_lat", lat, 3);
    chk("ld10_data", rd, 32'hDEAD_BEEF);
    chk("ld10_err", er, 1'b0);

    // 2: byte-enable merge; store does not disturb rsp_rdata
    txn(1'b1, 32'h8, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lat);
    chk("st8_rdata_hold", rd, 32'hDEAD_BEEF);
    txn(1'b1, 32'h8, 32'h1122_3344, 4'b0101, 0, rd, er, lat);
    chk("st8_be_err", er, 1'b0);
    txn(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld8_merge", rd, 32'hFF22_FF44);
    txn(1'b1, 32'h8, 32'h0BAD_0BAD, 4'b0000, 0, rd, er, lat);
    chk("st8_be0_err", er, 1'b0);
    txn(1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld8_be0_nop", rd, 32'hFF22_FF44);

    // 3: faults
    txn(1'b0, 32'h6, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld6_err", er, 1'b1);
    chk("ld6_data", rd, 32'h0);
    txn(1'b1, 32'h0, 32'hA5A5_A5A5, 4'hF, 0, rd, er, lat);
    txn(1'b1, 32'h1000, 32'h1234_5678, 4'hF, 0, rd, er, lat);
    chk("st1000_err", er, 1'b1);
    txn(1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld0_unchanged", rd, 32'hA5A5_A5A5);
    chk("ld0_err", er, 1'b0);

    // 5: reset during WAIT of a store
    txn(1'b1, 32'h4, 32'h55AA_55AA, 4'hF, 0, rd, er, lat);
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h4; req_wdata = 32'h9999_9999; req_be = 4'hF;
    req_valid_a = 1'b1;
    @(posedge clk);
    #1 req_valid_a = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_a, 1'b0);
    chk("mid_rst_ready", req_ready_a, 1'b1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("mid_rst_no_rsp", rsp_valid_a, 1'b0);
    end
    rst_n = 1'b1;
    txn(1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat);
    chk("ld4_after_rst", rd, 32'h55AA_55AA);

    // 6: request fields wiggle while busy
    txn(1'b1, 32'hC, 32'hCAFE_F00D, 4'hF, 0, rd, er, lat);
    txn(1'b0, 32'hC, 32'h0, 4'h0, 1, rd, er, lat);
    chk("ldC_latched", rd, 32'hCAFE_F00D);
    chk("ldC_err", er, 1'b0);

    // 4: zero-wait unit, req_valid held high
    @(negedge clk);
    req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h1357_2468; req_be = 4'hF;
    req_valid_b = 1'b1;
    @(negedge clk);
    chk("b_st_rsp", rsp_valid_b, 1'b1);
    chk("b_st_ready", req_ready_b, 1'b0);
    chk("b_st_err", rsp_err_b, 1'b0);
    req_we = 1'b0;
    @(negedge clk);
    chk("b_idle_rsp", rsp_valid_b, 1'b0);
    chk("b_idle_ready", req_ready_b, 1'b1);
    chk("b_idle_busy", busy_b, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("b_pulse", rsp_valid_b, (i % 2 == 0) ? 1'b1 : 1'b0);
      chk("b_ready", req_ready_b, (i % 2 == 0) ? 1'b0 : 1'b1);
      if (i % 2 == 0) chk("b_ld_data", rsp_rdata_b, 32'h1357_2468);
    end
    req_valid_b = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("b_quiet", rsp_valid_b, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
